// File: rtl/uart_frame_pkg.sv
// Shared types and sizing helpers for the UART frame assembler.
// Used by uart_frame_assembler and uart_frame_xor.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    CHECK
  } frame_state_t;

  localparam int DEFAULT_FRAME_BYTES = 80;

  function automatic int count_width(input int frame_bytes);
    return $clog2(frame_bytes + 1);
  endfunction

endpackage

// File: rtl/uart_frame_xor.sv
// Running XOR accumulator used to verify the optional per-frame checksum byte.
// When clear and enable are both high, the accumulator restarts with data.
module uart_frame_xor
  import uart_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] acc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 8'h00;
    end else begin
      acc <= (clear ? 8'h00 : acc) ^ (enable ? data : 8'h00);
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Packs UART receiver bytes into FRAME_BYTES-wide frames behind a valid/ack handshake.
// Define FRAME_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module uart_frame_assembler
  import uart_frame_pkg::*;
#(
  parameter int FRAME_BYTES = DEFAULT_FRAME_BYTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_data_ready,
  input  logic                     rx_busy,
  input  logic                     rx_error,
  output logic [8*FRAME_BYTES-1:0] frame_data,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic                     err_framing,
  output logic                     err_gap,
  output logic                     err_overrun,
  output logic                     err_checksum,
  input  logic                     err_clear
);

  localparam int W  = 8 * FRAME_BYTES;
  localparam int CW = count_width(FRAME_BYTES);

  frame_state_t  state;
  logic [CW-1:0] count;
  logic [W-1:0]  shift;
  logic [W-1:0]  next_shift;
  logic [W-1:0]  frame_next;
  logic          last_data;
  logic          byte_ev;
  logic          gap_ev;
  logic          complete;
  logic          overrun_hit;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       ck_bad;

  uart_frame_xor u_xor (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == IDLE),
    .enable (byte_ev && (state != CHECK)),
    .data   (rx_byte),
    .acc    (xor_acc)
  );
`endif

  always_comb begin
    next_shift  = {rx_byte, shift[W-1:8]};
    last_data   = (count == CW'(FRAME_BYTES - 1));
    byte_ev     = rx_data_ready && !rx_error;
    gap_ev      = !rx_busy && !rx_data_ready && !rx_error && (state != IDLE);
    complete    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
    ck_bad      = 1'b0;
    frame_next  = shift;
    if (byte_ev && state == CHECK) begin
      if (xor_acc == rx_byte) complete = 1'b1;
      else                    ck_bad   = 1'b1;
    end
`else
    frame_next  = next_shift;
    if (byte_ev && state == COLLECT && last_data) complete = 1'b1;
`endif
    overrun_hit = complete && frame_valid && !frame_ack;
  end

  // Event priority: framing error, then byte strobe, then idle-line gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= '0;
      shift       <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      err_framing <= 1'b0;
      err_gap     <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (rx_error) begin
        state <= IDLE;
        count <= '0;
      end else if (rx_data_ready) begin
        case (state)
          IDLE: begin
            shift <= next_shift;
            count <= CW'(1);
            state <= COLLECT;
          end
          COLLECT: begin
            shift <= next_shift;
            if (last_data) begin
              count <= '0;
`ifdef FRAME_CHECKSUM_EN
              state <= CHECK;
`else
              state <= IDLE;
`endif
            end else begin
              count <= count + CW'(1);
            end
          end
`ifdef FRAME_CHECKSUM_EN
          CHECK: begin
            count <= '0;
            state <= IDLE;
          end
`endif
          default: begin
            count <= '0;
            state <= IDLE;
          end
        endcase
      end else if (gap_ev) begin
        state <= IDLE;
        count <= '0;
      end

      // A same-edge ack frees the output register for the completing frame.
      if (complete && (!frame_valid || frame_ack)) begin
        frame_data  <= frame_next;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ack) begin
        frame_valid <= 1'b0;
      end

      err_framing <= rx_error    | (err_framing & ~err_clear);
      err_gap     <= gap_ev      | (err_gap     & ~err_clear);
      err_overrun <= overrun_hit | (err_overrun & ~err_clear);
    end
  end

`ifdef FRAME_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_checksum <= 1'b0;
    else        err_checksum <= ck_bad | (err_checksum & ~err_clear);
  end
`else
  assign err_checksum = 1'b0;
`endif

endmodule
